// File: rtl/datamem_responder_if.sv
// Request/response bus between the pipeline memory stage and the data-memory responder.
// The master modport is the CPU side and the slave modport is the responder side.
interface datamem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/datamem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency, registered response.
// Byte-addressed little-endian storage of DEPTH 64-bit words; array contents survive reset.
module datamem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  datamem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [3:0]  size_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;

  logic [63:0] mem [DEPTH];

  logic          size_ok, align_ok, range_ok, acc_err;
  logic [AW-1:0] word_idx;
  logic [5:0]    shift;
  logic [7:0]    size_bytes, byte_en;
  logic [63:0]   bit_mask, rd_word, load_data, wr_word;

  // Legality and byte-lane decode all work on the latched request, so inputs may change after accept.
  always_comb begin
    size_ok    = (size_q == 4'd1) || (size_q == 4'd2) || (size_q == 4'd4) || (size_q == 4'd8);
    align_ok   = (addr_q & (64'(size_q) - 64'd1)) == 64'd0;
    range_ok   = ({1'b0, addr_q} + 65'(size_q)) <= 65'(DEPTH * 8);
    acc_err    = !(size_ok && align_ok && range_ok);
    word_idx   = addr_q[AW+2:3];
    shift      = {addr_q[2:0], 3'b000};
    size_bytes = 8'h00;
    case (size_q)
      4'd1:    size_bytes = 8'h01;
      4'd2:    size_bytes = 8'h03;
      4'd4:    size_bytes = 8'h0F;
      4'd8:    size_bytes = 8'hFF;
      default: size_bytes = 8'h00;
    endcase
    byte_en  = size_bytes << addr_q[2:0];
    bit_mask = '0;
    for (int b = 0; b < 8; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_en[b]}};
    end
    rd_word   = mem[word_idx];
    load_data = (rd_word & bit_mask) >> shift;
    wr_word   = (rd_word & ~bit_mask) | ((wdata_q << shift) & bit_mask);
  end

  // Array write happens on the access edge only; reset forces IDLE so a pending store is dropped.
  always_ff @(posedge clk) begin
    if (state == BUSY && cnt == 4'd0 && write_q && !acc_err) begin
      mem[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            size_q      <= bus.req_size;
            cnt         <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            resp_rdata_q <= (!acc_err && !write_q) ? load_data : 64'd0;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
